// File: rtl/polybius_stream_codec_if.sv
// Byte-stream handshake bundle for polybius_stream_codec: input and output valid/ready channels.
interface polybius_stream_codec_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/polybius_stream_codec.sv
// Streaming Polybius-square codec: encrypt letter -> row/col digits, decrypt digit pair -> letter.
// Define POLYBIUS_PASSTHRU_EN to forward unrecognised bytes unchanged instead of flagging err.
module polybius_stream_codec #(
    parameter int unsigned GRID   = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    polybius_stream_codec_if.slave        bus,
    output logic                          err,
    output logic                          busy
);
    localparam int unsigned IDX_W = 6;
    localparam int unsigned ROW_W = 3;

    typedef enum logic [2:0] {
        IDLE, ENC_ROW, ENC_COL, DEC_COL, DEC_OUT
`ifdef POLYBIUS_PASSTHRU_EN
        , PASS
`endif
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  row_q;
    logic [DATA_W-1:0] col_q;

    logic [IDX_W:0]    enc_hit;
    logic              in_digit;
    logic [ROW_W-1:0]  in_coord;
    logic [IDX_W-1:0]  dec_idx;
    logic [DATA_W-1:0] dec_char;

    // Returns {hit, idx}; lowercase folds to uppercase, J shares I's cell in the 5x5 grid.
    function automatic logic [IDX_W:0] char_to_idx(input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] u;
        logic [IDX_W:0]    r;
        u = c;
        r = '0;
        if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
        if (u >= 8'h41 && u <= 8'h5A) begin
            r = {1'b1, IDX_W'(u - 8'h41)};
            if (GRID == 5 && u > 8'h49) r[IDX_W-1:0] = r[IDX_W-1:0] - IDX_W'(1);
        end else if (GRID == 6 && u >= 8'h30 && u <= 8'h39) begin
            r = {1'b1, IDX_W'(u - 8'h30 + 8'd26)};
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] idx_to_char(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] c;
        if (GRID == 5 && idx > IDX_W'(8))
            c = 8'h42 + DATA_W'(idx);
        else if (GRID == 6 && idx > IDX_W'(25))
            c = 8'h30 + DATA_W'(idx - IDX_W'(26));
        else
            c = 8'h41 + DATA_W'(idx);
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] row_digit(input logic [IDX_W-1:0] idx);
        return DATA_W'(32'(idx) / GRID + 32'h31);
    endfunction

    function automatic logic [DATA_W-1:0] col_digit(input logic [IDX_W-1:0] idx);
        return DATA_W'(32'(idx) % GRID + 32'h31);
    endfunction

    // Lookup on the byte currently presented; row_q holds the zero-based row in DEC_COL.
    always_comb begin
        enc_hit  = char_to_idx(bus.in_data);
        in_digit = (bus.in_data >= 8'h31) && (32'(bus.in_data) <= 32'h30 + GRID);
        in_coord = ROW_W'(bus.in_data - 8'h31);
        dec_idx  = IDX_W'(32'(row_q) * GRID + 32'(in_coord));
        dec_char = idx_to_char(dec_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    busy         <= 1'b0;
                    if (bus.in_valid && bus.in_ready) begin
                        if (!mode && enc_hit[IDX_W]) begin
                            state         <= ENC_ROW;
                            bus.in_ready  <= 1'b0;
                            busy          <= 1'b1;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= row_digit(enc_hit[IDX_W-1:0]);
                            col_q         <= col_digit(enc_hit[IDX_W-1:0]);
                        end else if (mode && in_digit) begin
                            state <= DEC_COL;
                            busy  <= 1'b1;
                            row_q <= in_coord;
                        end else begin
`ifdef POLYBIUS_PASSTHRU_EN
                            state         <= PASS;
                            bus.in_ready  <= 1'b0;
                            busy          <= 1'b1;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= bus.in_data;
`else
                            err <= 1'b1;
`endif
                        end
                    end
                end
                ENC_ROW: begin
                    if (bus.out_ready) begin
                        state        <= ENC_COL;
                        bus.out_data <= col_q;
                    end
                end
                DEC_COL: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (in_digit) begin
                            state         <= DEC_OUT;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= dec_char;
                        end else begin
                            // Bad column digit discards the whole pair.
                            state <= IDLE;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            row_q <= '0;
                        end
                    end
                end
`ifdef POLYBIUS_PASSTHRU_EN
                PASS,
`endif
                ENC_COL,
                DEC_OUT: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_polybius_stream_codec.sv
// Directed self-checking bench for polybius_stream_codec with one 5x5 and one 6x6 instance.
module tb_polybius_stream_codec;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mode5, mode6, err5, err6, busy5, busy6;
    int   checks = 0;
    int   errors = 0;

    polybius_stream_codec_if #(.DATA_W(8)) b5 ();
    polybius_stream_codec_if #(.DATA_W(8)) b6 ();

    polybius_stream_codec #(.GRID(5), .DATA_W(8)) u5 (
        .clk(clk), .rst(rst), .mode(mode5), .bus(b5), .err(err5), .busy(busy5)
    );
    polybius_stream_codec #(.GRID(6), .DATA_W(8)) u6 (
        .clk(clk), .rst(rst), .mode(mode6), .bus(b6), .err(err6), .busy(busy6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ov(input int g);
        return (g == 5) ? b5.out_valid : b6.out_valid;
    endfunction

    function automatic logic [7:0] od(input int g);
        return (g == 5) ? b5.out_data : b6.out_data;
    endfunction

    // Presents one byte until accepted; returns just after the accepting edge.
    task automatic drive(input int g, input logic m, input logic [7:0] d, output bit ok);
        ok = 1'b0;
        if (g == 5) begin b5.in_valid = 1'b1; b5.in_data = d; mode5 = m; end
        else        begin b6.in_valid = 1'b1; b6.in_data = d; mode6 = m; end
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = (g == 5) ? b5.in_ready : b6.in_ready;
            tick();
        end
        if (g == 5) b5.in_valid = 1'b0;
        else        b6.in_valid = 1'b0;
    endtask

    // Waits for an output byte and steps past its handshake edge (out_ready must be high).
    task automatic recv(input int g, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ov(g)) begin ok = 1'b1; d = od(g); end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (b5.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", b5.out_valid); end
        checks++; if (b5.out_data !== 8'h00) begin errors++; $display("FAIL reset out_data: got %h expected 00", b5.out_data); end
        checks++; if (err5 !== 1'b0) begin errors++; $display("FAIL reset err: got %b expected 0", err5); end
        checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy5); end
        checks++; if (b5.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready5: got %b expected 0", b5.in_ready); end
        checks++; if (b6.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready6: got %b expected 0", b6.in_ready); end
        rst = 1'b0;
        tick();
        checks++; if (b5.in_ready !== 1'b1) begin errors++; $display("FAIL idle in_ready: got %b expected 1", b5.in_ready); end
    endtask

    task automatic test_encrypt_h();
        bit ok;
        b5.out_ready = 1'b1;
        drive(5, 1'b0, 8'h48, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL enc_h accept: got %b expected 1", ok); end
        checks++; if (b5.out_valid !== 1'b1 || b5.out_data !== 8'h32) begin errors++; $display("FAIL enc_h row: got v=%b d=%h expected v=1 d=32", b5.out_valid, b5.out_data); end
        checks++; if (b5.in_ready !== 1'b0 || busy5 !== 1'b1) begin errors++; $display("FAIL enc_h ready1: got rdy=%b busy=%b expected rdy=0 busy=1", b5.in_ready, busy5); end
        tick();
        checks++; if (b5.out_valid !== 1'b1 || b5.out_data !== 8'h33) begin errors++; $display("FAIL enc_h col: got v=%b d=%h expected v=1 d=33", b5.out_valid, b5.out_data); end
        checks++; if (b5.in_ready !== 1'b0) begin errors++; $display("FAIL enc_h ready2: got %b expected 0", b5.in_ready); end
        tick();
        checks++; if (b5.out_valid !== 1'b0 || b5.in_ready !== 1'b1 || err5 !== 1'b0) begin errors++; $display("FAIL enc_h done: got v=%b rdy=%b err=%b expected 0 1 0", b5.out_valid, b5.in_ready, err5); end
    endtask

    task automatic test_fold_and_skip();
        logic [7:0] ch  [3] = '{8'h4A, 8'h6A, 8'h5A};
        logic [7:0] exr [3] = '{8'h32, 8'h32, 8'h35};
        logic [7:0] exc [3] = '{8'h34, 8'h34, 8'h35};
        logic [7:0] r, c;
        bit a, ok1, ok2;
        b5.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5, 1'b0, ch[i], a);
            recv(5, r, ok1);
            recv(5, c, ok2);
            checks++; if (!(a && ok1 && ok2) || r !== exr[i] || c !== exc[i]) begin
                errors++; $display("FAIL fold_%0d char %h: got %h %h (ok %b%b%b) expected %h %h", i, ch[i], r, c, a, ok1, ok2, exr[i], exc[i]);
            end
        end
    endtask

    task automatic test_grid6_and_decrypt();
        logic [7:0] r, c;
        bit a, b, ok1, ok2;
        b5.out_ready = 1'b1;
        b6.out_ready = 1'b1;
        drive(6, 1'b0, 8'h37, a); recv(6, r, ok1); recv(6, c, ok2);
        checks++; if (!(a && ok1 && ok2) || r !== 8'h36 || c !== 8'h34) begin errors++; $display("FAIL g6_enc_7: got %h %h expected 36 34", r, c); end
        drive(6, 1'b0, 8'h30, a); recv(6, r, ok1); recv(6, c, ok2);
        checks++; if (!(a && ok1 && ok2) || r !== 8'h35 || c !== 8'h33) begin errors++; $display("FAIL g6_enc_0: got %h %h expected 35 33", r, c); end
        drive(5, 1'b1, 8'h33, a); drive(5, 1'b1, 8'h34, b); recv(5, r, ok1);
        checks++; if (!(a && b && ok1) || r !== 8'h4F) begin errors++; $display("FAIL g5_dec_34: got %h expected 4f", r); end
        drive(6, 1'b1, 8'h36, a); drive(6, 1'b1, 8'h36, b); recv(6, r, ok1);
        checks++; if (!(a && b && ok1) || r !== 8'h39) begin errors++; $display("FAIL g6_dec_66: got %h expected 39", r); end
        drive(5, 1'b1, 8'h32, a); drive(5, 1'b1, 8'h34, b); recv(5, r, ok1);
        checks++; if (!(a && b && ok1) || r !== 8'h49) begin errors++; $display("FAIL g5_dec_24: got %h expected 49", r); end
        drive(6, 1'b1, 8'h31, a); drive(6, 1'b1, 8'h31, b); recv(6, r, ok1);
        checks++; if (!(a && b && ok1) || r !== 8'h41) begin errors++; $display("FAIL g6_dec_11: got %h expected 41", r); end
        mode5 = 1'b0;
        mode6 = 1'b0;
    endtask

    task automatic test_backpressure();
        bit a;
        int held_bad = 0;
        b5.out_ready = 1'b0;
        drive(5, 1'b0, 8'h48, a);
        for (int i = 0; i < 5; i++) begin
            if (b5.out_valid !== 1'b1 || b5.out_data !== 8'h32) held_bad++;
            tick();
        end
        checks++; if (!a || held_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles (accept %b) expected 0", held_bad, a); end
        b5.out_ready = 1'b1;
        checks++; if (b5.out_valid !== 1'b1 || b5.out_data !== 8'h32) begin errors++; $display("FAIL bp_row: got v=%b d=%h expected v=1 d=32", b5.out_valid, b5.out_data); end
        tick();
        checks++; if (b5.out_valid !== 1'b1 || b5.out_data !== 8'h33) begin errors++; $display("FAIL bp_col: got v=%b d=%h expected v=1 d=33", b5.out_valid, b5.out_data); end
        tick();
        checks++; if (b5.out_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got %b expected 0", b5.out_valid); end
        tick();
        checks++; if (b5.out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup: got %b expected 0", b5.out_valid); end
    endtask

    task automatic test_invalid();
        bit a, b;
        b5.out_ready = 1'b1;
        drive(5, 1'b0, 8'h40, a);
`ifdef POLYBIUS_PASSTHRU_EN
        checks++; if (!a || b5.out_valid !== 1'b1 || b5.out_data !== 8'h40 || err5 !== 1'b0) begin errors++; $display("FAIL pass_at: got v=%b d=%h err=%b expected v=1 d=40 err=0", b5.out_valid, b5.out_data, err5); end
        tick();
        checks++; if (b5.out_valid !== 1'b0) begin errors++; $display("FAIL pass_once: got %b expected 0", b5.out_valid); end
`else
        checks++; if (!a || err5 !== 1'b1 || b5.out_valid !== 1'b0 || busy5 !== 1'b0) begin errors++; $display("FAIL inv_at: got err=%b v=%b busy=%b expected 1 0 0", err5, b5.out_valid, busy5); end
        tick();
        checks++; if (err5 !== 1'b0 || b5.out_valid !== 1'b0) begin errors++; $display("FAIL inv_at_pulse: got err=%b v=%b expected 0 0", err5, b5.out_valid); end
`endif
        drive(5, 1'b1, 8'h32, a);
        drive(5, 1'b1, 8'h39, b);
        checks++; if (!(a && b) || err5 !== 1'b1 || b5.out_valid !== 1'b0 || busy5 !== 1'b0) begin errors++; $display("FAIL dec_29: got err=%b v=%b busy=%b expected 1 0 0", err5, b5.out_valid, busy5); end
        tick();
        checks++; if (err5 !== 1'b0 || b5.in_ready !== 1'b1) begin errors++; $display("FAIL dec_29_idle: got err=%b rdy=%b expected 0 1", err5, b5.in_ready); end
        mode5 = 1'b0;
    endtask

    task automatic test_mode_ignored();
        logic [7:0] r, c;
        bit a, ok1, ok2;
        b5.out_ready = 1'b0;
        drive(5, 1'b0, 8'h42, a);
        mode5 = 1'b1;
        b5.out_ready = 1'b1;
        recv(5, r, ok1);
        recv(5, c, ok2);
        checks++; if (!(a && ok1 && ok2) || r !== 8'h31 || c !== 8'h32) begin errors++; $display("FAIL mode_hold: got %h %h expected 31 32", r, c); end
        mode5 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, c;
        bit a, ok1, ok2;
        b5.out_ready = 1'b0;
        drive(5, 1'b0, 8'h48, a);
        b5.out_ready = 1'b1;
        tick();
        b5.out_ready = 1'b0;
        checks++; if (!a || b5.out_data !== 8'h33 || busy5 !== 1'b1) begin errors++; $display("FAIL mid_col: got d=%h busy=%b expected d=33 busy=1", b5.out_data, busy5); end
        rst = 1'b1;
        tick();
        checks++; if (b5.out_valid !== 1'b0 || busy5 !== 1'b0 || b5.out_data !== 8'h00) begin errors++; $display("FAIL mid_rst: got v=%b busy=%b d=%h expected 0 0 00", b5.out_valid, busy5, b5.out_data); end
        rst = 1'b0;
        tick();
        b5.out_ready = 1'b1;
        drive(5, 1'b0, 8'h41, a);
        recv(5, r, ok1);
        recv(5, c, ok2);
        checks++; if (!(a && ok1 && ok2) || r !== 8'h31 || c !== 8'h31) begin errors++; $display("FAIL mid_after_a: got %h %h expected 31 31", r, c); end
    endtask

    initial begin
        rst = 1'b1;
        mode5 = 1'b0; mode6 = 1'b0;
        b5.in_valid = 1'b0; b5.in_data = 8'h00; b5.out_ready = 1'b0;
        b6.in_valid = 1'b0; b6.in_data = 8'h00; b6.out_ready = 1'b0;
        test_reset();
        test_encrypt_h();
        test_fold_and_skip();
        test_grid6_and_decrypt();
        test_backpressure();
        test_invalid();
        test_mode_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/polybius_stream_codec.md
Name: polybius_stream_codec

Overview:
- Sequential, parametrised successor to the combinational Polybius encrypt block.
- Streams ASCII bytes through a valid/ready interface.
- Encrypt mode: one letter in, two ASCII coordinate digits out (row, then column).
- Decrypt mode: two digit bytes in, one letter out. Sits between the UART/byte-stream front end and the cipher output path.

Parameters:
- GRID, 5, square size; 5 = A–Z with J merged into I (25 cells); 6 = A–Z then 0–9 (36 cells); other values illegal.
- DATA_W, 8, byte width of in_data/out_data; must be 8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = encrypt, 1 = decrypt; sampled only when a symbol starts
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  DATA_W  ASCII input byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  DATA_W  ASCII output byte
- err  out  1  one-cycle pulse: rejected input byte
- busy  out  1  high whenever FSM not in IDLE

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset values: out_valid=0, out_data=0x00, err=0, busy=0, in_ready=0 while rst high; state=IDLE.
- Transfer occurs when valid && ready on the same clk edge. Once out_valid is high, out_data is held stable until out_ready.
- Lowercase a–z folds to uppercase before lookup.
- Cell index: A=0, letters in order; GRID=5 skips J, so J maps to I's index 8 and K=9; GRID=6 places digits '0'..'9' at indices 26..35.
- Coordinates: row = idx/GRID + 1, col = idx%GRID + 1, emitted as ASCII ('1'=0x31).
- States: IDLE, ENC_ROW, ENC_COL, DEC_COL, DEC_OUT.
- in_ready = 1 only in IDLE or DEC_COL.
- IDLE, accepting a byte:
  - Latch mode.
  - Encrypt with a valid char: go to ENC_ROW; out_valid rises the next cycle with the row digit.
  - Decrypt with a digit '1'..GRID: store the row; go to DEC_COL.
  - Invalid byte: err pulses the next cycle; stay in IDLE; no output.
- ENC_ROW: on the out_ready handshake, load the col digit and go to ENC_COL.
- ENC_COL: on handshake, drop out_valid and go to IDLE. Minimum 3 cycles per encrypted char with out_ready tied high.
- DEC_COL:
  - Valid digit: compute idx = (row-1)*GRID + (col-1); go to DEC_OUT with the letter/digit on out_data the next cycle.
  - Invalid digit: err pulse; discard the stored row; go to IDLE.
- DEC_OUT: on handshake, go to IDLE.
- Changes on mode while not in IDLE are ignored.
- Simultaneous err and out_valid cannot occur; err is never asserted with out_valid.
- rst asserted in any state aborts the symbol immediately; a partially emitted pair is lost, with no trailing column.

Optional Feature:
- Macro: POLYBIUS_PASSTHRU_EN.
- Defined: a non-alphabet byte received in IDLE (either mode; non-digit in decrypt) does not raise err. It enters state PASS and is emitted unchanged as a single output byte after a 1-cycle latency, under the same handshake. Invalid bytes in DEC_COL still raise err.
- Undefined: PASS state absent; such bytes raise err and are dropped.

Test Plan:
- GRID=5, encrypt, out_ready=1, send 'H' (0x48) -> out 0x32 then 0x33; err=0; in_ready low for 2 cycles after acceptance.
- GRID=5, encrypt, send 'J', 'j', then 'Z' -> '2','4', '2','4', '5','5'.
- GRID=6, encrypt '7' -> '6','4'; decrypt '3','4' at GRID=5 -> 'O' (0x4F); decrypt '6','6' at GRID=6 -> '9'.
- Backpressure: encrypt 'H' with out_ready=0 for 5 cycles -> out_data stays 0x32 with out_valid=1 throughout; then '3' after release; no byte lost or duplicated.
- Invalid input: encrypt '@' -> err pulse 1 cycle, no out_valid (macro undefined); with POLYBIUS_PASSTHRU_EN defined, 0x40 emitted once. Decrypt '2','9' at GRID=5 -> err, back to IDLE.
- Reset mid-op: assert rst in ENC_COL -> next cycle out_valid=0, busy=0, out_data=0x00; a subsequent 'A' encrypts to '1','1'.
